// File: rtl/mem_wb_if.sv
// mem_wb_if -- Wishbone-style single-port memory bus.
//
// Carries the request (we, strb, addr, wdata) from a master and the
// response (rdata, ack) from a slave. The clock and reset are kept
// outside the bundle as plain ports on the modules that use it.
//
//   master modport : drives we/strb/addr/wdata, observes rdata/ack
//   slave  modport : observes we/strb/addr/wdata, drives rdata/ack
interface mem_wb_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic                  strb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;

    modport master (
        output we, strb, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  we, strb, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_wb_slave.sv
// mem_wb_slave -- Wishbone-style memory slave, 2**ADDR_WIDTH words deep.
//
// A three-state controller (IDLE -> ACCESS -> DONE) services one transfer
// every three clocks. The request is captured in IDLE, the memory is
// accessed on the following edge (raising ack), and DONE drops ack and
// returns to IDLE. Synchronous reset clears the controller, rdata and
// every memory word.
//
// Ports (top, positional order fixed):
//   clk   in   rising-edge clock
//   we    in   1 = write, 0 = read
//   strb  in   request present while high
//   rst   in   synchronous active-high reset
//   addr  in   word address
//   wdata in   write data
//   rdata out  registered read data, changes only on a read
//   ack   out  one-cycle registered transfer acknowledge

// Core controller + storage, bus-facing through the slave modport.
module mem_wb_core #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  mem_wr;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Next-state / datapath.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                // The only place the bus request is sampled; everything
                // after this edge works from the latched copy.
                if (bus.strb) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ack_d   = 1'b1;
                state_d = DONE;
                if (we_q) begin
                    mem_wr = 1'b1;
                end else begin
                    rdata_d = mem_q[addr_q];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    // Storage is register-based so reset can clear every word in one edge;
    // a reset landing in ACCESS therefore suppresses the pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_wr) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
endmodule

module mem_wb_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  strb,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack
);
    // Flat ports keep positional instantiation working; internally the
    // signals are bundled onto the bus interface.
    mem_wb_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) bus ();

    assign bus.we    = we;
    assign bus.strb  = strb;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;
    assign rdata     = bus.rdata;
    assign ack       = bus.ack;

    mem_wb_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
endmodule

// File: tb/tb_mem_wb_slave.sv
// tb_mem_wb_slave -- self-checking bench for mem_wb_slave.
//
// A transaction-timeline model (word array + one pending request) predicts
// ack and rdata every cycle; directed sequences pin literal values.
module tb_mem_wb_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_wb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) tb_bus ();

    mem_wb_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .we    (tb_bus.we),
        .strb  (tb_bus.strb),
        .rst   (rst),
        .addr  (tb_bus.addr),
        .wdata (tb_bus.wdata),
        .rdata (tb_bus.rdata),
        .ack   (tb_bus.ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A request seen with strb high at edge c (when the slave is free) is
    // acknowledged by edge c+1 and the slave can take a new one at c+3.
    int          cyc     = 0;
    int          free_at = 0;
    bit          p_valid = 1'b0;
    int          p_cyc   = 0;
    logic        p_we    = 1'b0;
    logic [7:0]  p_addr  = '0;
    logic [31:0] p_wdata = '0;
    logic [31:0] mmem [256];
    logic [31:0] m_rdata = '0;
    logic        m_ack   = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 256; i++) mmem[i] <= '0;
            m_rdata <= '0;
            m_ack   <= 1'b0;
            p_valid <= 1'b0;
            free_at <= cyc + 1;
        end else begin
            m_ack <= 1'b0;
            if (p_valid && cyc == p_cyc + 1) begin
                m_ack   <= 1'b1;
                p_valid <= 1'b0;
                if (p_we) mmem[p_addr] <= p_wdata;
                else      m_rdata      <= mmem[p_addr];
            end
            if (tb_bus.strb && cyc >= free_at) begin
                p_valid <= 1'b1;
                p_cyc   <= cyc;
                p_we    <= tb_bus.we;
                p_addr  <= tb_bus.addr;
                p_wdata <= tb_bus.wdata;
                free_at <= cyc + 3;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack_cycle", 32'(tb_bus.ack), 32'(m_ack));
            chk("rdata_cycle", tb_bus.rdata, m_rdata);
        end
    end

    // One transfer; inputs are scrambled right after the sampling edge to
    // show the latched request is what gets serviced.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        int n;
        @(negedge clk);
        tb_bus.we = w; tb_bus.addr = a; tb_bus.wdata = d; tb_bus.strb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_bus.strb  = 1'($urandom_range(0, 1));
        tb_bus.we    = 1'($urandom);
        tb_bus.addr  = 8'($urandom);
        tb_bus.wdata = $urandom;
        n = 1;
        while (!tb_bus.ack && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("ack_latency", 32'(n), 32'd2);
        rd = tb_bus.rdata;
        tb_bus.strb = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_d;
    int          last_ack;
    int          n;

    initial begin
        tb_bus.we = 1'b0; tb_bus.strb = 1'b0; tb_bus.addr = '0; tb_bus.wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ack", 32'(tb_bus.ack), 32'd0);
        chk("reset_rdata", tb_bus.rdata, 32'd0);
        rst = 1'b0;

        // Fresh read after reset.
        do_txn(1'b0, 8'h05, 32'h0, rd);
        chk("read_unwritten_05", rd, 32'h0000_0000);

        // Write then read back; rdata must not move during the write.
        do_txn(1'b1, 8'h10, 32'hDEAD_BEEF, rd);
        chk("rdata_hold_on_write", rd, 32'h0000_0000);
        do_txn(1'b0, 8'h10, 32'h0, rd);
        chk("read_back_10", rd, 32'hDEAD_BEEF);

        // Top address, no aliasing onto 0.
        do_txn(1'b1, 8'hFF, 32'hFFFF_FFFF, rd);
        do_txn(1'b0, 8'hFF, 32'h0, rd);
        chk("read_top_ff", rd, 32'hFFFF_FFFF);
        do_txn(1'b0, 8'h00, 32'h0, rd);
        chk("read_zero_00", rd, 32'h0000_0000);

        // Back-to-back with strb held: alternate write/read of the same word.
        @(negedge clk);
        tb_bus.strb = 1'b1;
        tb_bus.we = 1'b1; tb_bus.addr = 8'h30; tb_bus.wdata = 32'hC0DE_0000;
        last_ack = -1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tb_bus.ack && n < 8);
            chk("b2b_ack_seen", 32'(tb_bus.ack), 32'd1);
            if (last_ack >= 0) chk("b2b_ack_spacing", 32'(cyc - last_ack), 32'd3);
            last_ack = cyc;
            if (k % 2 == 1) begin
                exp_d = 32'hC0DE_0000 + 32'(k - 1);
                chk("b2b_read_data", tb_bus.rdata, exp_d);
            end
            // Next request; it is sampled two edges from now (after DONE).
            if (k % 2 == 0) begin
                tb_bus.we = 1'b0;
                tb_bus.addr = 8'h30 + 8'(k / 2);
            end else begin
                tb_bus.we = 1'b1;
                tb_bus.addr = 8'h30 + 8'((k + 1) / 2);
                tb_bus.wdata = 32'hC0DE_0000 + 32'(k + 1);
            end
        end
        // Drop strb before the DONE edge so no extra transfer is started.
        tb_bus.strb = 1'b0;
        repeat (3) @(negedge clk);

        // Reset landing in ACCESS of a write aborts it.
        tb_bus.we = 1'b1; tb_bus.addr = 8'h20; tb_bus.wdata = 32'h1234_5678; tb_bus.strb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_bus.strb = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_ack", 32'(tb_bus.ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_late_ack", 32'(tb_bus.ack), 32'd0);
        do_txn(1'b0, 8'h20, 32'h0, rd);
        chk("abort_read_20", rd, 32'h0000_0000);
        do_txn(1'b0, 8'h10, 32'h0, rd);
        chk("reset_cleared_10", rd, 32'h0000_0000);

        // Random traffic over a small window so reads hit earlier writes.
        for (int t = 0; t < 20; t++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            do_txn(1'($urandom), a, $urandom, rd);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case the DUT hangs somewhere unexpected.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete, failures=%0d", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
